// File: rtl/dm_arbiter_pkg.sv
// Shared constants and helpers for the two-master data-memory arbiter.
package dm_arbiter_pkg;

    localparam logic       M0            = 1'b0;
    localparam logic       M1            = 1'b1;
    localparam logic [3:0] DM_BE_NONE    = 4'b0000;
    localparam logic [3:0] DM_BE_WORD    = 4'b1111;
    localparam int         DM_ADDR_W_DEF = 12;

    // A word access must fit entirely inside the decoded window.
    function automatic logic dm_addr_legal(input logic [31:0] addr, input int unsigned aw);
        return (addr <= ((32'd1 << aw) - 32'd4));
    endfunction

endpackage

// File: rtl/dm_arbiter_if.sv
// One master's request/response bundle towards the data-memory arbiter.
interface dm_arbiter_if;
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;

    modport master (output req, we, be, addr, wdata, input gnt, rvalid, rdata, err);
    modport slave  (input req, we, be, addr, wdata, output gnt, rvalid, rdata, err);
endinterface

// File: rtl/dm_arb_rsp.sv
// Registered response path of one master: read data, read-valid and error pulse.
module dm_arb_rsp (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_gnt,
    input  logic        i_we,
    input  logic        i_legal,
    input  logic [31:0] i_dm_out,
    output logic        o_rvalid,
    output logic [31:0] o_rdata,
    output logic        o_err
);

    logic        r_rvalid;
    logic [31:0] r_rdata;
    logic        r_err;
    logic        w_rd_hit;

    assign w_rd_hit = i_gnt && i_legal && !i_we;

    // Capture read data on a legal read grant; flag rejected grants.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rvalid <= 1'b0;
            r_rdata  <= 32'h0000_0000;
            r_err    <= 1'b0;
        end else begin
            r_rvalid <= w_rd_hit;
            r_err    <= i_gnt && !i_legal;
            if (w_rd_hit) begin
                r_rdata <= i_dm_out;
            end
        end
    end

    assign o_rvalid = r_rvalid;
    assign o_rdata  = r_rdata;
    assign o_err    = r_err;

endmodule

// File: rtl/dm_arbiter.sv
// Round-robin arbiter with bounded master-1 lock and address guard in front of dm.
module dm_arbiter
    import dm_arbiter_pkg::*;
#(
    parameter int ADDR_W   = DM_ADDR_W_DEF,
    parameter int MAX_LOCK = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    dm_arbiter_if.slave   m0,
    dm_arbiter_if.slave   m1,
    input  logic          m1_lock,
    output logic          dm_en,
    output logic [3:0]    dm_byte,
    output logic [31:0]   dm_addr,
    output logic [31:0]   dm_in,
    input  logic [31:0]   dm_out
);

    localparam int              CNT_W   = $clog2(MAX_LOCK + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_LOCK);

    logic             r_ptr;
    logic             r_lock_act;
    logic [CNT_W-1:0] r_lock_cnt;
    logic             w_ptr_nxt;
    logic             w_lock_act_nxt;
    logic [CNT_W-1:0] w_lock_cnt_nxt;
    logic             w_forced;
    logic             w_sel_vld;
    logic             w_sel;
    logic             w_we;
    logic [3:0]       w_be;
    logic [31:0]      w_addr;
    logic [31:0]      w_wdata;
    logic             w_legal;
    logic             w_gnt0;
    logic             w_gnt1;

    // State register: round-robin pointer and lock tracking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr      <= M0;
            r_lock_act <= 1'b0;
            r_lock_cnt <= '0;
        end else begin
            r_ptr      <= w_ptr_nxt;
            r_lock_act <= w_lock_act_nxt;
            r_lock_cnt <= w_lock_cnt_nxt;
        end
    end

    // Selection: lock holds m1 until its budget runs out while m0 waits.
    always_comb begin
        w_forced  = r_lock_act && m1.req && m0.req && (r_lock_cnt == CNT_MAX);
        w_sel_vld = 1'b0;
        w_sel     = M0;
        if (w_forced) begin
            w_sel_vld = 1'b1;
            w_sel     = M0;
        end else if (r_lock_act && m1.req) begin
            w_sel_vld = 1'b1;
            w_sel     = M1;
        end else if (m0.req && m1.req) begin
            w_sel_vld = 1'b1;
            w_sel     = r_ptr;
        end else if (m0.req) begin
            w_sel_vld = 1'b1;
            w_sel     = M0;
        end else if (m1.req) begin
            w_sel_vld = 1'b1;
            w_sel     = M1;
        end else begin
            w_sel_vld = 1'b0;
            w_sel     = M0;
        end
    end

    // Next state for pointer and lock.
    always_comb begin
        w_ptr_nxt      = r_ptr;
        w_lock_act_nxt = r_lock_act;
        w_lock_cnt_nxt = r_lock_cnt;
        if (w_sel_vld) begin
            w_ptr_nxt = (w_sel == M0) ? M1 : M0;
        end else begin
            w_ptr_nxt = r_ptr;
        end
        if (w_forced) begin
            w_lock_act_nxt = 1'b0;
            w_lock_cnt_nxt = '0;
        end else if (w_sel_vld && (w_sel == M1) && m1_lock) begin
            w_lock_act_nxt = 1'b1;
            if (m0.req && (r_lock_cnt != CNT_MAX)) begin
                w_lock_cnt_nxt = r_lock_cnt + CNT_W'(1);
            end else begin
                w_lock_cnt_nxt = r_lock_cnt;
            end
        end else if (!m1.req || !m1_lock) begin
            w_lock_act_nxt = 1'b0;
            w_lock_cnt_nxt = '0;
        end else begin
            w_lock_act_nxt = r_lock_act;
            w_lock_cnt_nxt = r_lock_cnt;
        end
    end

    // Route the selected master's request fields.
    always_comb begin
        if (w_sel == M1) begin
            w_we    = m1.we;
            w_be    = m1.be;
            w_addr  = m1.addr;
            w_wdata = m1.wdata;
        end else begin
            w_we    = m0.we;
            w_be    = m0.be;
            w_addr  = m0.addr;
            w_wdata = m0.wdata;
        end
    end

    assign w_legal = w_sel_vld && dm_addr_legal(w_addr, ADDR_W);
    assign w_gnt0  = w_sel_vld && (w_sel == M0);
    assign w_gnt1  = w_sel_vld && (w_sel == M1);
    assign m0.gnt  = w_gnt0;
    assign m1.gnt  = w_gnt1;

    // Memory port drive; rejected or absent accesses leave dm fully quiet.
    always_comb begin
        if (w_legal) begin
            dm_en   = 1'b1;
            dm_byte = w_we ? w_be : DM_BE_NONE;
            dm_addr = w_addr;
            dm_in   = w_wdata;
        end else begin
            dm_en   = 1'b0;
            dm_byte = DM_BE_NONE;
            dm_addr = 32'h0000_0000;
            dm_in   = 32'h0000_0000;
        end
    end

    dm_arb_rsp u_rsp0 (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_gnt    (w_gnt0),
        .i_we     (m0.we),
        .i_legal  (w_legal),
        .i_dm_out (dm_out),
        .o_rvalid (m0.rvalid),
        .o_rdata  (m0.rdata),
        .o_err    (m0.err)
    );

    dm_arb_rsp u_rsp1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_gnt    (w_gnt1),
        .i_we     (m1.we),
        .i_legal  (w_legal),
        .i_dm_out (dm_out),
        .o_rvalid (m1.rvalid),
        .o_rdata  (m1.rdata),
        .o_err    (m1.err)
    );

endmodule
